// File: rtl/paged_read_arbiter_pkg.sv
// Shared constants for the paged memory read path: AR FSM states and ID port tagging.
package paged_read_arbiter_pkg;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_t;

    localparam int OUTSTANDING_CNT_W = 4;

    // The requesting port number is carried in the top bit of the master-side ID.
    function automatic int port_sel_bit(input int id_width);
        return id_width - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; the port not granted last wins a tie.
module rr_arbiter2 (
    input  logic       aclk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    logic last_q;

    always_comb begin
        grant_o     = 2'b00;
        grant_idx_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_idx_o = ~last_q;
            grant_o     = last_q ? 2'b01 : 2'b10;
        end else if (req_i[0]) begin
            grant_o     = 2'b01;
            grant_idx_o = 1'b0;
        end else if (req_i[1]) begin
            grant_o     = 2'b10;
            grant_idx_o = 1'b1;
        end
    end

    // Reset to "port 1 granted last" so port 0 wins the first tie.
    always_ff @(posedge aclk_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else if (advance_i && (grant_o != 2'b00)) begin
            last_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/paged_read_arbiter.sv
// Two-port AXI4 read arbiter: round-robin AR with port-tagged IDs, R routed back by ID.
//   state    | meaning
//   AR_IDLE  | looking for an eligible requester; accepting grants this cycle
//   AR_ISSUE | registered request presented on m_axi_ar*, waiting for m_axi_arready
module paged_read_arbiter
    import paged_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [ID_WIDTH-2:0]   s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic                  s0_axi_arlock,
    input  logic [3:0]            s0_axi_arcache,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [ID_WIDTH-2:0]   s0_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ID_WIDTH-2:0]   s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic                  s1_axi_arlock,
    input  logic [3:0]            s1_axi_arcache,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [ID_WIDTH-2:0]   s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int SEL = port_sel_bit(ID_WIDTH);
    localparam logic [OUTSTANDING_CNT_W-1:0] MAX_CNT = OUTSTANDING_CNT_W'(MAX_OUTSTANDING);

    ar_state_t state_q, state_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  arlock_q, arlock_d;
    logic [3:0]            arcache_q, arcache_d;
    logic [2:0]            arprot_q, arprot_d;
    logic                  arvalid_q, arvalid_d;
    logic [OUTSTANDING_CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic [1:0] req, grant;
    logic       grant_idx, r_sel, r_last_hs, inc0, inc1, dec0, dec1;

    // Grants are suppressed during reset so no arready pulse is lost to a discarded request.
    assign req[0] = s0_axi_arvalid && (cnt0_q < MAX_CNT);
    assign req[1] = s1_axi_arvalid && (cnt1_q < MAX_CNT);

    rr_arbiter2 u_rr (
        .aclk_i      (aclk),
        .reset_i     (reset),
        .req_i       ((state_q == AR_IDLE && !reset) ? req : 2'b00),
        .advance_i   (1'b1),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign s0_axi_arready = grant[0];
    assign s1_axi_arready = grant[1];

    always_comb begin
        state_d   = state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arlock_d  = arlock_q;
        arcache_d = arcache_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        case (state_q)
            AR_IDLE: begin
                if (grant != 2'b00) begin
                    arid_d    = {grant_idx, grant_idx ? s1_axi_arid : s0_axi_arid};
                    araddr_d  = grant_idx ? s1_axi_araddr  : s0_axi_araddr;
                    arlen_d   = grant_idx ? s1_axi_arlen   : s0_axi_arlen;
                    arsize_d  = grant_idx ? s1_axi_arsize  : s0_axi_arsize;
                    arburst_d = grant_idx ? s1_axi_arburst : s0_axi_arburst;
                    arlock_d  = grant_idx ? s1_axi_arlock  : s0_axi_arlock;
                    arcache_d = grant_idx ? s1_axi_arcache : s0_axi_arcache;
                    arprot_d  = grant_idx ? s1_axi_arprot  : s0_axi_arprot;
                    arvalid_d = 1'b1;
                    state_d   = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    assign r_sel     = m_axi_rid[SEL];
    assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign inc0 = (state_q == AR_ISSUE) && m_axi_arready && !arid_q[SEL];
    assign inc1 = (state_q == AR_ISSUE) && m_axi_arready &&  arid_q[SEL];
    assign dec0 = r_last_hs && !r_sel && (cnt0_q != '0);
    assign dec1 = r_last_hs &&  r_sel && (cnt1_q != '0);

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (inc0 && !dec0) cnt0_d = cnt0_q + 1'b1;
        if (dec0 && !inc0) cnt0_d = cnt0_q - 1'b1;
        if (inc1 && !dec1) cnt1_d = cnt1_q + 1'b1;
        if (dec1 && !inc1) cnt1_d = cnt1_q - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q   <= AR_IDLE;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arlock_q  <= 1'b0;
            arcache_q <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arlock_q  <= arlock_d;
            arcache_q <= arcache_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arlock  = arlock_q;
    assign m_axi_arcache = arcache_q;
    assign m_axi_arprot  = arprot_q;
    assign m_axi_arvalid = arvalid_q;

    // R payload fans out to both ports; only rvalid and rready are steered by the ID tag.
    assign s0_axi_rid    = m_axi_rid[ID_WIDTH-2:0];
    assign s1_axi_rid    = m_axi_rid[ID_WIDTH-2:0];
    assign s0_axi_rdata  = m_axi_rdata;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s0_axi_rlast  = m_axi_rlast;
    assign s1_axi_rlast  = m_axi_rlast;
    assign s0_axi_rvalid = m_axi_rvalid && !r_sel;
    assign s1_axi_rvalid = m_axi_rvalid &&  r_sel;
    assign m_axi_rready  = r_sel ? s1_axi_rready : s0_axi_rready;

endmodule

// File: tb/tb_paged_read_arbiter.sv
// Directed bench for paged_read_arbiter: grants, ID tagging, limits, R routing, reset.
module tb_paged_read_arbiter;

    logic        aclk = 1'b0;
    logic        reset;
    logic [6:0]  s0_axi_arid, s1_axi_arid;
    logic [31:0] s0_axi_araddr, s1_axi_araddr;
    logic [7:0]  s0_axi_arlen, s1_axi_arlen;
    logic [2:0]  s0_axi_arsize, s1_axi_arsize;
    logic [1:0]  s0_axi_arburst, s1_axi_arburst;
    logic        s0_axi_arlock, s1_axi_arlock;
    logic [3:0]  s0_axi_arcache, s1_axi_arcache;
    logic [2:0]  s0_axi_arprot, s1_axi_arprot;
    logic        s0_axi_arvalid, s1_axi_arvalid;
    logic        s0_axi_arready, s1_axi_arready;
    logic [6:0]  s0_axi_rid, s1_axi_rid;
    logic [31:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0]  s0_axi_rresp, s1_axi_rresp;
    logic        s0_axi_rlast, s1_axi_rlast;
    logic        s0_axi_rvalid, s1_axi_rvalid;
    logic        s0_axi_rready, s1_axi_rready;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid, m_axi_arready;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int total = 0;
    int bad   = 0;

    paged_read_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(4)
    ) dut (
        .aclk(aclk), .reset(reset),
        .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
        .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
        .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
        .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
        .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-beat R transfer with rlast for the given port.
    task automatic rbeat(input logic port);
        m_axi_rvalid  = 1'b1;
        m_axi_rid     = {port, 7'h01};
        m_axi_rlast   = 1'b1;
        m_axi_rdata   = $urandom;
        s0_axi_rready = 1'b1;
        s1_axi_rready = 1'b1;
        tick();
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        s0_axi_rready = 1'b0;
        s1_axi_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int acc;
        reset = 1'b1;
        s0_axi_arid = '0; s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arsize = '0;
        s0_axi_arburst = '0; s0_axi_arlock = 1'b0; s0_axi_arcache = '0; s0_axi_arprot = '0;
        s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
        s1_axi_arid = '0; s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arsize = '0;
        s1_axi_arburst = '0; s1_axi_arlock = 1'b0; s1_axi_arcache = '0; s1_axi_arprot = '0;
        s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arid", m_axi_arid, 0);
        chk("rst_cnt0", dut.cnt0_q, 0);

        // Single request from s0
        s0_axi_arvalid = 1'b1; s0_axi_araddr = 32'h1000; s0_axi_arlen = 8'd255; s0_axi_arid = 7'd3;
        #1;
        chk("single_s0_arready", s0_axi_arready, 1);
        chk("single_s1_arready", s1_axi_arready, 0);
        chk("single_arvalid_T", m_axi_arvalid, 0);
        tick();
        s0_axi_arvalid = 1'b0;
        chk("single_arvalid", m_axi_arvalid, 1);
        chk("single_araddr", m_axi_araddr, 32'h1000);
        chk("single_arid", m_axi_arid, 8'h03);
        chk("single_arlen", m_axi_arlen, 8'd255);
        chk("single_arready_issue", s0_axi_arready, 0);
        m_axi_arready = 1'b1;
        tick();
        chk("single_arvalid_drop", m_axi_arvalid, 0);
        chk("single_cnt0_one", dut.cnt0_q, 1);

        for (int b = 0; b < 256; b++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h03; m_axi_rdata = 32'hD000_0000 + b;
            m_axi_rresp = 2'b01; m_axi_rlast = (b == 255); s0_axi_rready = 1'b1;
            #1;
            chk("burst_s0_rvalid", s0_axi_rvalid, 1);
            chk("burst_s1_rvalid", s1_axi_rvalid, 0);
            chk("burst_s0_rdata", s0_axi_rdata, 32'hD000_0000 + b);
            if (b == 255) begin
                chk("burst_s0_rid", s0_axi_rid, 7'h03);
                chk("burst_s0_rresp", s0_axi_rresp, 2'b01);
                chk("burst_s0_rlast", s0_axi_rlast, 1);
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0; m_axi_rresp = 2'b00;
        chk("burst_cnt0_zero", dut.cnt0_q, 0);

        // Contention: last grant was s0, so s1 goes first
        s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1; s1_axi_arid = 7'h22;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("cont_s1_arready", s1_axi_arready, (i % 4) == 0);
            chk("cont_s0_arready", s0_axi_arready, (i % 4) == 2);
            chk("cont_arvalid", m_axi_arvalid, (i % 2) == 1);
            if (i % 2 == 1) chk("cont_port_tag", m_axi_arid[7], (i % 4) == 1);
            tick();
        end
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
        chk("cont_cnt0", dut.cnt0_q, 3);
        chk("cont_cnt1", dut.cnt1_q, 3);
        repeat (3) rbeat(1'b0);
        repeat (3) rbeat(1'b1);
        chk("drain_cnt0", dut.cnt0_q, 0);
        chk("drain_cnt1", dut.cnt1_q, 0);

        // Outstanding limit on s0
        g = 0;
        s0_axi_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s0_axi_arready) g++;
            tick();
        end
        chk("limit_grants", g, 4);
        chk("limit_blocked", s0_axi_arready, 0);
        s1_axi_arvalid = 1'b1; s1_axi_arid = 7'h11;
        #1;
        chk("limit_s1_granted", s1_axi_arready, 1);
        tick();
        s1_axi_arvalid = 1'b0;
        chk("limit_s1_arid", m_axi_arid, 8'h91);
        tick();
        rbeat(1'b0);
        g = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (s0_axi_arready) g++;
            tick();
        end
        s0_axi_arvalid = 1'b0;
        chk("limit_unblock_one", g, 1);
        chk("limit_cnt0", dut.cnt0_q, 4);
        chk("limit_cnt1", dut.cnt1_q, 1);

        // Increment and decrement in the same cycle
        rbeat(1'b0); rbeat(1'b0); rbeat(1'b1);
        chk("simul_pre_cnt0", dut.cnt0_q, 2);
        s0_axi_arvalid = 1'b1;
        tick();
        s0_axi_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rid = 8'h05; m_axi_rlast = 1'b1; s0_axi_rready = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0;
        chk("simul_cnt0", dut.cnt0_q, 2);
        chk("simul_arvalid", m_axi_arvalid, 0);
        rbeat(1'b0); rbeat(1'b0); rbeat(1'b0);
        chk("stray_cnt0", dut.cnt0_q, 0);
        chk("stray_cnt1", dut.cnt1_q, 0);

        // AR backpressure: fields must hold while s inputs change
        m_axi_arready = 1'b0;
        s1_axi_arvalid = 1'b1; s1_axi_arid = 7'h55; s1_axi_araddr = 32'hABCD_0000; s1_axi_arlen = 8'd7;
        s1_axi_arsize = 3'd2; s1_axi_arburst = 2'd1; s1_axi_arlock = 1'b1; s1_axi_arcache = 4'hF;
        s1_axi_arprot = 3'd5;
        #1;
        chk("bp_s1_arready", s1_axi_arready, 1);
        tick();
        s1_axi_araddr = 32'h1234_5678; s1_axi_arlen = 8'd0; s1_axi_arid = 7'h00; s1_axi_arcache = 4'h0;
        s1_axi_arsize = 3'd0; s1_axi_arburst = 2'd0; s1_axi_arlock = 1'b0; s1_axi_arprot = 3'd0;
        s0_axi_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_arvalid", m_axi_arvalid, 1);
            chk("bp_araddr", m_axi_araddr, 32'hABCD_0000);
            chk("bp_arid", m_axi_arid, 8'hD5);
            chk("bp_attr", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
                {8'd7, 3'd2, 2'd1, 1'b1, 4'hF, 3'd5});
            chk("bp_no_arready", {s0_axi_arready, s1_axi_arready}, 2'b00);
            tick();
        end
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0; m_axi_arready = 1'b1;
        tick();
        chk("bp_done", m_axi_arvalid, 0);
        chk("bp_cnt1", dut.cnt1_q, 1);

        // R burst to s1 with toggling rready
        acc = 0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'hD5; m_axi_rdata = 32'hB000 + acc;
            m_axi_rlast = (acc == 7); s1_axi_rready = (c % 2) == 0;
            #1;
            chk("rbp_rready", m_axi_rready, (c % 2) == 0);
            chk("rbp_rdata", s1_axi_rdata, 32'hB000 + acc);
            chk("rbp_s0_rvalid", s0_axi_rvalid, 0);
            chk("rbp_s1_rvalid", s1_axi_rvalid, 1);
            if (acc == 7) chk("rbp_rlast", {s1_axi_rlast, s1_axi_rid, s1_axi_rresp}, {1'b1, 7'h55, 2'b00});
            if (c == 0) chk("rbp_cnt1_hold", dut.cnt1_q, 1);
            if ((c % 2) == 0) acc++;
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s1_axi_rready = 1'b0;
        chk("rbp_cnt1_zero", dut.cnt1_q, 0);

        // Reset while a request is in ISSUE
        s1_axi_arvalid = 1'b1;
        tick();
        s1_axi_arvalid = 1'b0;
        tick();
        chk("rst_pre_cnt1", dut.cnt1_q, 1);
        m_axi_arready = 1'b0;
        s0_axi_arvalid = 1'b1; s0_axi_araddr = 32'h2000;
        tick();
        s0_axi_arvalid = 1'b0;
        chk("rst_pre_arvalid", m_axi_arvalid, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_arvalid", m_axi_arvalid, 0);
        chk("rst_mid_cnts", {dut.cnt0_q, dut.cnt1_q}, 8'h00);
        chk("rst_mid_araddr", m_axi_araddr, 0);
        reset = 1'b0;
        s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
        #1;
        chk("rst_post_s0_first", s0_axi_arready, 1);
        chk("rst_post_s1_wait", s1_axi_arready, 0);
        tick();
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
        chk("rst_post_tag", m_axi_arid[7], 0);
        m_axi_arready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
